instr_prefetch_unit: RTL and testbench

Instruction prefetch unit sitting directly upstream of the fetch stage: it issues sequential word reads to an external instruction memory over a request/grant/response handshake, buffers returned words with their PCs in a small FIFO, and presents one instruction per cycle to the fetch stage. On a taken branch or jump it flushes its buffer, discards in-flight responses and restarts at the supplied target.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/prefetch_fifo.sv | 70 +++++++
 rtl/instr_prefetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared core types and constants for the fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [31:0] c_PC_INC  = 32'd4;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [XLEN-1:0] instr_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// Module   : prefetch_fifo
// Brief    : Synchronous FIFO with flush and occupancy count; push while full
//            is accepted when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       pop,
    output logic [WIDTH-1:0]           popData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    // Explicit wrap keeps non-power-of-two depths (tag queue) correct.
    function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    assign popData  = r_mem[r_rdPtr];
    assign w_doPop  = pop & ~empty & ~flush;
    assign w_doPush = push & (~full | w_doPop) & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            if (w_doPush && !w_doPop)      r_count <= r_count + CW'(1);
            else if (!w_doPush && w_doPop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= pushData;
    end

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_unit.sv
// ============================================================================
// Module   : instr_prefetch_unit
// Brief    : Sequential instruction prefetcher with redirect flush and
//            in-flight response discard. Optional PREFETCH_BYPASS_EN forwards
//            a response straight to the fetch stage when the buffer is empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_prefetch_unit #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic        ValidF,
    input  logic        ReadyF,
    output logic [31:0] InstrF,
    output logic [31:0] PCF
);

    import riscv_pkg::*;

    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    pc_t          r_fetchPc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_discard;
    logic [OW-1:0] w_outNext;
    logic          w_credit;
    logic          w_grant;
    logic          w_resp;
    logic          w_keep;
    logic          w_bufPush;
    logic          w_bufPop;
    logic          w_bufEmpty;
    logic          w_bufFull;
    logic [CW-1:0] w_bufCount;
    fetch_entry_t  w_bufHead;
    fetch_entry_t  w_respEntry;
    fetch_entry_t  w_outEntry;
    pc_t           w_tagHead;
    logic [OW-1:0] w_tagCount;
    logic          w_tagEmpty;
    logic          w_tagFull;
    logic          w_unused;

    assign w_credit = (r_outstanding < OW'(MAX_OUTSTANDING)) &&
                      ((SW'(w_bufCount) + SW'(r_outstanding)) < SW'(DEPTH));
    assign IMemReq  = rst & w_credit;
    assign IMemAddr = r_fetchPc;
    assign w_grant  = IMemReq & IMemGnt;
    assign w_resp   = IMemRValid & (r_outstanding != '0);
    assign w_keep   = w_resp & (r_discard == '0) & ~PCSrcE;

    assign w_respEntry = '{pc: w_tagHead, instr: IMemRData};

    always_comb begin
        w_outNext = r_outstanding;
        if (w_grant && !w_resp)      w_outNext = r_outstanding + OW'(1);
        else if (!w_grant && w_resp) w_outNext = r_outstanding - OW'(1);
    end

    // Tags stay paired with every in-flight request, including ones that
    // will be discarded, so the queue head always matches the next response.
    prefetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tagQueue (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (w_grant),
        .pushData (r_fetchPc),
        .pop      (w_resp),
        .popData  (w_tagHead),
        .count    (w_tagCount),
        .empty    (w_tagEmpty),
        .full     (w_tagFull)
    );

    prefetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instrBuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (PCSrcE),
        .push     (w_bufPush),
        .pushData (w_respEntry),
        .pop      (w_bufPop),
        .popData  (w_bufHead),
        .count    (w_bufCount),
        .empty    (w_bufEmpty),
        .full     (w_bufFull)
    );

    assign w_bufPop = ReadyF & ~w_bufEmpty;

`ifdef PREFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass   = w_keep & w_bufEmpty;
    assign ValidF     = ~w_bufEmpty | w_bypass;
    assign w_outEntry = w_bufEmpty ? w_respEntry : w_bufHead;
    assign w_bufPush  = w_keep & ~(w_bypass & ReadyF);
`else
    assign ValidF     = ~w_bufEmpty;
    assign w_outEntry = w_bufHead;
    assign w_bufPush  = w_keep;
`endif

    // Stale buffer contents must never leak out while nothing is valid.
    assign InstrF = ValidF ? w_outEntry.instr : '0;
    assign PCF    = ValidF ? w_outEntry.pc    : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetchPc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outNext;
            if (PCSrcE) begin
                r_fetchPc <= PCTargetE;
                r_discard <= w_outNext;
            end else begin
                if (w_grant) r_fetchPc <= r_fetchPc + c_PC_INC;
                if (w_resp && (r_discard != '0)) r_discard <= r_discard - OW'(1);
            end
        end
    end

    assign w_unused = ^{w_tagCount, w_tagEmpty, w_tagFull, w_bufFull};

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
// ============================================================================
// Module   : tb_instr_prefetch_unit
// Brief    : Directed scoreboard bench for instr_prefetch_unit with a
//            latency-configurable in-order memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        ValidF;
    logic        ReadyF = 1'b0;
    logic [31:0] InstrF;
    logic [31:0] PCF;

    instr_prefetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemGnt    (IMemGnt),
        .IMemRValid (IMemRValid),
        .IMemRData  (IMemRData),
        .ValidF     (ValidF),
        .ReadyF     (ReadyF),
        .InstrF     (InstrF),
        .PCF        (PCF)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [31:0] expQ[$];
    logic [31:0] pendAddr[$];
    int          pendDue[$];
    bit          gntEn = 1'b0;
    int          lat = 1;
    int          budget = 0;
    int          grantCount = 0;
    logic [31:0] monExp;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // In-order memory: drives at negedge+1, samples handshakes at negedge+3.
    initial begin
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                pendAddr.delete(); pendDue.delete();
                IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = '0;
            end else begin
                IMemRValid = 1'b0;
                if (pendAddr.size() > 0) IMemRValid = (pendDue[0] <= cyc);
                IMemRData = IMemRValid ? memWord(pendAddr[0]) : 32'h0;
                IMemGnt   = gntEn && (budget > 0);
                #2;
                if (IMemRValid) begin
                    void'(pendAddr.pop_front());
                    void'(pendDue.pop_front());
                end
                if (IMemReq && IMemGnt) begin
                    pendAddr.push_back(IMemAddr);
                    pendDue.push_back(cyc + lat);
                    budget--;
                    grantCount++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst && ValidF && ReadyF) begin
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("FAIL unexpected_output: got PCF %h, expected no output", PCF);
                end else begin
                    monExp = expQ.pop_front();
                    if (PCF !== monExp || InstrF !== memWord(monExp)) begin
                        nMismatched++;
                        $display("FAIL fetch_output: got PCF %h InstrF %h, expected PCF %h InstrF %h",
                                 PCF, InstrF, monExp, memWord(monExp));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic resetDut(input int n);
        rst = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; ReadyF = 1'b0;
        gntEn = 1'b0; budget = 0; grantCount = 0; expQ.delete();
        repeat (n) @(negedge clk);
        #4;
        chk("rst_IMemReq",  32'(IMemReq), 32'd0);
        chk("rst_IMemAddr", IMemAddr,     32'h0);
        chk("rst_ValidF",   32'(ValidF),  32'd0);
        chk("rst_InstrF",   InstrF,       32'h0);
        chk("rst_PCF",      PCF,          32'h0);
    endtask

    task automatic waitDrain(input string name, input int limit);
        int i = 0;
        while (expQ.size() != 0 && i < limit) begin
            @(negedge clk);
            #4;
            i++;
        end
        chk({name, "_drained"}, 32'(expQ.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic pushSeq(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) expQ.push_back(base + 32'(4 * k));
    endtask

    initial begin
        // A: streaming at one instruction per cycle
        resetDut(2);
        lat = 1; gntEn = 1'b1; budget = 8; pushSeq(32'h0, 8);
        @(negedge clk); rst = 1'b1; ReadyF = 1'b1; #4;
        chk("A_c1_IMemReq",  32'(IMemReq), 32'd1);
        chk("A_c1_IMemAddr", IMemAddr,     32'h0);
        @(negedge clk); #4;
        chk("A_c2_ValidF", 32'(ValidF), 32'd0);
        @(negedge clk); #4;
        chk("A_c3_ValidF", 32'(ValidF), 32'd1);
        chk("A_c3_PCF",    PCF,         32'h0);
        for (int c = 4; c <= 10; c++) begin
            @(negedge clk); #4;
            chk("A_stream_ValidF", 32'(ValidF), 32'd1);
        end
        waitDrain("A", 20);

        // B: backpressure fills the buffer and stops requests
        resetDut(2);
        lat = 1; gntEn = 1'b1; budget = 8; pushSeq(32'h0, 8);
        @(negedge clk); rst = 1'b1; ReadyF = 1'b0;
        repeat (9) @(negedge clk);
        #4;
        chk("B_full_IMemReq", 32'(IMemReq), 32'd0);
        chk("B_grants",       32'(grantCount), 32'd4);
        chk("B_ValidF",       32'(ValidF), 32'd1);
        chk("B_PCF",          PCF,         32'h0);
        @(negedge clk); ReadyF = 1'b1;
        waitDrain("B", 40);

        // C: redirect with two requests in flight
        resetDut(2);
        lat = 3; gntEn = 1'b1; budget = 6; pushSeq(32'h100, 4);
        @(negedge clk); rst = 1'b1; ReadyF = 1'b1;
        @(negedge clk);
        @(negedge clk); PCSrcE = 1'b1; PCTargetE = 32'h100; #4;
        chk("C_c3_IMemReq", 32'(IMemReq), 32'd0);
        @(negedge clk); PCSrcE = 1'b0; #4;
        chk("C_c4_IMemAddr", IMemAddr,     32'h100);
        chk("C_c4_ValidF",   32'(ValidF),  32'd0);
        waitDrain("C", 60);

        // D: redirect coinciding with a grant and a response
        resetDut(2);
        lat = 1; gntEn = 1'b1; budget = 5; pushSeq(32'h200, 3);
        @(negedge clk); rst = 1'b1; ReadyF = 1'b1;
        @(negedge clk); PCSrcE = 1'b1; PCTargetE = 32'h200; #4;
        chk("D_c2_IMemReq", 32'(IMemReq), 32'd1);
        @(negedge clk); PCSrcE = 1'b0; #4;
        chk("D_c3_IMemAddr", IMemAddr,    32'h200);
        chk("D_c3_ValidF",   32'(ValidF), 32'd0);
        waitDrain("D", 40);

        // E: fetch address wraps past the top of the address space
        resetDut(2);
        lat = 1; gntEn = 1'b0; budget = 4; pushSeq(32'hFFFF_FFF8, 4);
        @(negedge clk); rst = 1'b1; ReadyF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        @(negedge clk); PCSrcE = 1'b0; gntEn = 1'b1; #4;
        chk("E_addr_fff8", IMemAddr, 32'hFFFF_FFF8);
        @(negedge clk); #4;
        chk("E_addr_fffc", IMemAddr, 32'hFFFF_FFFC);
        @(negedge clk); #4;
        chk("E_addr_wrap", IMemAddr, 32'h0000_0000);
        waitDrain("E", 40);

        // F: reset while buffer occupied and responses pending
        resetDut(2);
        lat = 2; gntEn = 1'b0; budget = 10;
        @(negedge clk); rst = 1'b1; ReadyF = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h80;
        @(negedge clk); PCSrcE = 1'b0; gntEn = 1'b1;
        repeat (4) @(negedge clk);
        #4;
        chk("F_pre_ValidF", 32'(ValidF), 32'd1);
        chk("F_pre_PCF",    PCF,         32'h80);
        resetDut(1);
        lat = 1; gntEn = 1'b1; budget = 2; pushSeq(32'h0, 2);
        @(negedge clk); rst = 1'b1; ReadyF = 1'b1; #4;
        chk("F_post_IMemReq",  32'(IMemReq), 32'd1);
        chk("F_post_IMemAddr", IMemAddr,     32'h0);
        waitDrain("F", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
